// File: rtl/isa_core.sv
// rtl/isa_core.sv - multi-cycle RV32I subset core (ADDI, LUI, BNE) with retire trace port
module isa_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        rdv,
  output logic [4:0]  rd_x,
  output logic [31:0] rd_data,
  output logic        pcv,
  output logic [31:0] pc_x,
  output logic        halted,
  output logic [31:0] instret
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] rf_q [32];

  logic        valid_q, valid_d;
  logic [31:0] ret_pc_q, ret_pc_d;
  logic [31:0] ret_inst_q, ret_inst_d;
  logic        rdv_q, rdv_d;
  logic [4:0]  rd_x_q, rd_x_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        pcv_q, pcv_d;
  logic [31:0] pc_x_q, pc_x_d;
  logic        halted_q, halted_d;
  logic [31:0] instret_q, instret_d;

  logic [4:0]  opcode, rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] i_imm, u_imm, b_imm;
  logic [31:0] rs1_val, rs2_val;
  logic        is_addi, is_lui, is_bne, legal;
  logic        wr_en, taken;
  logic [31:0] wr_data, br_target;

  assign opcode = ir_q[6:2];
  assign funct3 = ir_q[14:12];
  assign rd     = ir_q[11:7];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign i_imm  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign u_imm  = {ir_q[31:12], 12'b0};
  assign b_imm  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

  // x0 entry is cleared on reset and never written, so it always reads zero
  assign rs1_val = rf_q[rs1];
  assign rs2_val = rf_q[rs2];

  assign is_addi = (ir_q[1:0] == 2'b11) && (opcode == OP_OPIMM) && (funct3 == 3'b000);
  assign is_lui  = (ir_q[1:0] == 2'b11) && (opcode == OP_LUI);
  assign is_bne  = (ir_q[1:0] == 2'b11) && (opcode == OP_BRANCH) && (funct3 == 3'b001);
  assign legal   = is_addi || is_lui || is_bne;

  assign wr_en     = (is_addi || is_lui) && (rd != 5'd0);
  assign wr_data   = is_lui ? u_imm : (rs1_val + i_imm);
  assign taken     = is_bne && (rs1_val != rs2_val);
  assign br_target = pc_q + b_imm;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    valid_d    = 1'b0;
    rdv_d      = 1'b0;
    pcv_d      = 1'b0;
    ret_pc_d   = ret_pc_q;
    ret_inst_d = ret_inst_q;
    rd_x_d     = rd_x_q;
    rd_data_d  = rd_data_q;
    pc_x_d     = pc_x_q;
    halted_d   = halted_q;
    instret_d  = instret_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        valid_d    = 1'b1;
        ret_pc_d   = pc_q;
        ret_inst_d = ir_q;
        rdv_d      = wr_en;
        rd_x_d     = rd;
        rd_data_d  = wr_en ? wr_data : 32'h0;
        pcv_d      = taken;
        pc_x_d     = taken ? br_target : 32'h0;
        instret_d  = instret_q + 32'd1;
        if (!legal) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          pc_d    = taken ? br_target : (pc_q + 32'd4);
          state_d = S_FETCH;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0;
      valid_q    <= 1'b0;
      ret_pc_q   <= 32'h0;
      ret_inst_q <= 32'h0;
      rdv_q      <= 1'b0;
      rd_x_q     <= 5'd0;
      rd_data_q  <= 32'h0;
      pcv_q      <= 1'b0;
      pc_x_q     <= 32'h0;
      halted_q   <= 1'b0;
      instret_q  <= 32'h0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      valid_q    <= valid_d;
      ret_pc_q   <= ret_pc_d;
      ret_inst_q <= ret_inst_d;
      rdv_q      <= rdv_d;
      rd_x_q     <= rd_x_d;
      rd_data_q  <= rd_data_d;
      pcv_q      <= pcv_d;
      pc_x_q     <= pc_x_d;
      halted_q   <= halted_d;
      instret_q  <= instret_d;
      if (state_q == S_EXEC && wr_en) rf_q[rd] <= wr_data;
    end
  end

  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign valid     = valid_q;
  assign pc        = ret_pc_q;
  assign inst      = ret_inst_q;
  assign rdv       = rdv_q;
  assign rd_x      = rd_x_q;
  assign rd_data   = rd_data_q;
  assign pcv       = pcv_q;
  assign pc_x      = pc_x_q;
  assign halted    = halted_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_isa_core.sv
// tb/tb_isa_core.sv - table-driven, scoreboarded bench for isa_core
module tb_isa_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        valid, rdv, pcv, halted;
  logic [31:0] pc, inst, rd_data, pc_x, instret;
  logic [4:0]  rd_x;

  isa_core #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .valid(valid), .pc(pc), .inst(inst), .rdv(rdv), .rd_x(rd_x), .rd_data(rd_data),
    .pcv(pcv), .pc_x(pc_x), .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rdv;
    logic [4:0]  rd_x;
    logic [31:0] rd_data;
    logic        pcv;
    logic [31:0] pc_x;
    int          delay;
  } vec_t;

  vec_t        sb[$];
  vec_t        vecs[11];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_instret = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Retire monitor: every strobe must match the oldest outstanding fetch
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_retire: got pc %h expected no retire", pc);
      end else begin
        vec_t e;
        e = sb.pop_front();
        exp_instret = exp_instret + 1;
        check("ret_pc", pc, e.pc);
        check("ret_inst", inst, e.inst);
        check("ret_rdv", {31'b0, rdv}, {31'b0, e.rdv});
        check("ret_rd_x", {27'b0, rd_x}, {27'b0, e.rd_x});
        check("ret_rd_data", rd_data, e.rd_data);
        check("ret_pcv", {31'b0, pcv}, {31'b0, e.pcv});
        check("ret_pc_x", pc_x, e.pc_x);
        check("ret_instret", instret, exp_instret);
      end
    end
  end

  task automatic wait_req(output bit ok);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 20);
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL req_timeout: got imem_req %b expected 1 within 20 cycles", imem_req);
    end
  endtask

  task automatic issue(input vec_t v);
    bit ok;
    wait_req(ok);
    check("fetch_addr", imem_addr, v.pc);
    for (int i = 0; i < v.delay; i++) begin
      @(negedge clk);
      check("stall_req", {31'b0, imem_req}, 32'd1);
      check("stall_addr", imem_addr, v.pc);
    end
    imem_ack = 1'b1;
    imem_rdata = v.inst;
    sb.push_back(v);
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  function automatic vec_t mk(input logic [31:0] p, input logic [31:0] i, input logic r,
                              input logic [4:0] x, input logic [31:0] d, input logic b,
                              input logic [31:0] t, input int dl);
    vec_t v;
    v.pc = p; v.inst = i; v.rdv = r; v.rd_x = x; v.rd_data = d;
    v.pcv = b; v.pc_x = t; v.delay = dl;
    return v;
  endfunction

  initial begin
    bit ok;
    vecs[0]  = mk(32'h00, 32'h123450B7, 1, 1,  32'h12345000, 0, 32'h0,  0);
    vecs[1]  = mk(32'h04, 32'hFFF08113, 1, 2,  32'h12344FFF, 0, 32'h0,  0);
    vecs[2]  = mk(32'h08, 32'hFE009EE3, 0, 29, 32'h0,        1, 32'h04, 1);
    vecs[3]  = mk(32'h04, 32'h00000093, 1, 1,  32'h0,        0, 32'h0,  0);
    vecs[4]  = mk(32'h08, 32'hFE009EE3, 0, 29, 32'h0,        0, 32'h0,  2);
    vecs[5]  = mk(32'h0C, 32'h00000013, 0, 0,  32'h0,        0, 32'h0,  5);
    vecs[6]  = mk(32'h10, 32'h00510013, 0, 0,  32'h0,        0, 32'h0,  0);
    vecs[7]  = mk(32'h14, 32'h00100213, 1, 4,  32'h1,        0, 32'h0,  1);
    vecs[8]  = mk(32'h18, 32'h00011463, 0, 8,  32'h0,        1, 32'h20, 0);
    vecs[9]  = mk(32'h20, 32'hFFFFF2B7, 1, 5,  32'hFFFFF000, 0, 32'h0,  3);
    vecs[10] = mk(32'h24, 32'hFFF28313, 1, 6,  32'hFFFFEFFF, 0, 32'h0,  0);

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_rdv", {31'b0, rdv}, 32'd0);
    check("rst_pcv", {31'b0, pcv}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_rd_x", {27'b0, rd_x}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_pc_x", pc_x, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) issue(vecs[i]);

    // Unimplemented funct3 halts the core
    issue(mk(32'h28, 32'h00002013, 0, 0, 32'h0, 0, 32'h0, 1));
    @(negedge clk);
    check("halt_set", {31'b0, halted}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'b1;
      @(negedge clk);
      check("halt_req", {31'b0, imem_req}, 32'd0);
      check("halt_instret", instret, 32'd12);
    end
    imem_ack = 1'b0;
    check("halt_addr", imem_addr, 32'h28);

    // Restart, then reset while waiting for the fetch at 0x10
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_instret = 0;
    check("rst2_halted", {31'b0, halted}, 32'd0);
    issue(mk(32'h00, 32'h00500093, 1, 1, 32'h5, 0, 32'h0, 0));
    issue(mk(32'h04, 32'h00000013, 0, 0, 32'h0, 0, 32'h0, 0));
    issue(mk(32'h08, 32'h00000013, 0, 0, 32'h0, 0, 32'h0, 0));
    issue(mk(32'h0C, 32'h00000013, 0, 0, 32'h0, 0, 32'h0, 0));
    wait_req(ok);
    check("pre_rst_addr", imem_addr, 32'h10);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h00000093;
    @(negedge clk);
    reset = 1'b1;
    imem_ack = 1'b0;
    exp_instret = 0;
    check("midrst_halted", {31'b0, halted}, 32'd0);
    check("midrst_instret", instret, 32'd0);
    check("midrst_addr", imem_addr, 32'd0);
    check("midrst_valid", {31'b0, valid}, 32'd0);
    issue(mk(32'h00, 32'h00008113, 1, 2, 32'h0, 0, 32'h0, 0));
    // Low opcode bits other than 2'b11 are illegal
    issue(mk(32'h04, 32'h00000010, 0, 0, 32'h0, 0, 32'h0, 0));
    @(negedge clk);
    check("halt2_set", {31'b0, halted}, 32'd1);
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/isa_core.md
# isa_core

Single-issue, multi-cycle RV32I execution core for the ISA simulator: fetches from an instruction-memory handshake port, executes the supported subset (ADDI family incl. li/mv/nop, BNE, LUI), and drives the per-instruction retire/trace interface (valid, pc, inst, rdv, rd_x, rd_data, pcv, pc_x) consumed directly by the trace printer. Halts on any unimplemented encoding.

## Interface

Parameters
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-low.
- imem_req  out  1  fetch request; high exactly while state = FETCH.
- imem_addr  out  32  fetch address = current PC (no alignment check).
- imem_ack  in  1  fetch accepted; imem_rdata valid in the same cycle.
- imem_rdata  in  32  instruction word.
- valid  out  1  one-cycle retire strobe.
- pc  out  32  PC of the retired instruction.
- inst  out  32  retired instruction word.
- rdv  out  1  register write performed by the retired instruction.
- rd_x  out  5  destination register index.
- rd_data  out  32  value written.
- pcv  out  1  taken-branch redirect.
- pc_x  out  32  redirect target.
- halted  out  1  sticky; set on an unimplemented instruction.
- instret  out  32  count of retire strobes, wraps mod 2^32.

## Operation

- States: FETCH, EXEC, HALT. Reset → FETCH.
- FETCH: imem_req=1, imem_addr=PC. When imem_ack=1, capture imem_rdata into IR → EXEC; otherwise stay and hold the address stable.
- EXEC (one cycle): decode IR; update regfile, PC, and retire registers; → FETCH, or → HALT if illegal.
- HALT: imem_req=0; all strobes 0; leaves only on reset.
- Decode: opcode = IR[6:2]; IR[1:0] must be 2'b11, otherwise illegal.
  - ADDI (OPIMM, funct3=000): x[rd] = x[rs1] + sext(IR[31:20]), mod 2^32.
  - LUI: x[rd] = {IR[31:12], 12'b0}.
  - BNE (BRANCH, funct3=001): compare x[rs1] with x[rs2]. b_imm = sext({IR[31], IR[7], IR[30:25], IR[11:8], 0}).
  - Any other opcode/funct3 is illegal.
- rdv=1 only for ADDI/LUI with rd≠0. rd=0 (nop) retires with rdv=0, and x0 stays 0.
- Branch taken: PC = pc + b_imm (mod 2^32), pcv=1, pc_x = target. Not taken or non-branch: PC = pc + 4 (mod 2^32), pcv=0.
- Illegal: retire with valid=1, rdv=0, pcv=0; set halted; PC unchanged; no regfile write.
- When rdv=0, rd_x/rd_data hold IR[11:7] and 0. When pcv=0, pc_x = 0.
- Regfile: x1..x31, 2 combinational read ports, 1 write port; all cleared on reset.
- instret increments on each valid=1, including the illegal retire.

## Timing

- Reset (reset=0 at a clock edge): state=FETCH, PC=RESET_PC, all regs 0. Outputs: valid=rdv=pcv=halted=0; pc=inst=rd_data=pc_x=0; rd_x=0; instret=0. imem_req goes to 1 in the first cycle after reset is released.
- Reset mid-fetch or mid-EXEC: abandons the instruction. No retire, and any ack in that cycle is ignored.
- imem_ack outside FETCH is ignored.
- Retire outputs are registered, loaded at the edge that ends EXEC, and visible for exactly one cycle (the next FETCH cycle). All strobes are 0 otherwise.
- Minimum 2 cycles/instruction (ack in first FETCH cycle). Each cycle of ack delay adds 1 cycle.
- A new fetch request overlaps the retire-strobe cycle. imem_addr in that cycle already equals the next PC (pc_x if pcv).
- Regfile write at the end of EXEC is visible to the next instruction's EXEC; no hazards exist.

## Test plan

- Reset, RESET_PC=0, ack tied 1, imem returns 0x123450B7 (lui x1,0x12345) → two cycles after reset release: valid=1, pc=0, inst=0x123450B7, rdv=1, rd_x=1, rd_data=0x12345000, pcv=0, instret=1, imem_addr=4.
- Then 0xFFF08113 (addi x2,x1,-1) → rd_x=2, rd_data=0x12344FFF. Then 0x00000013 (nop) → valid=1, rdv=0, x0 still reads 0.
- At pc=8 with x1≠0, 0xFE009EE3 (bne x1,x0,-4) → pcv=1, pc_x=4, next imem_addr=4. Repeat with x1=0 → pcv=0, next imem_addr=0xC.
- Hold imem_ack=0 for 5 cycles in FETCH → imem_req=1 and imem_addr stable throughout, valid=0. Ack on cycle 6 → retire 2 cycles later.
- Fetch 0x00002013 (slti, unimplemented) → valid=1, rdv=0, pcv=0, halted=1. Thereafter imem_req=0, no strobes, instret frozen for 20 cycles.
- Assert reset while waiting for ack at PC=0x10 with x1=5 → next cycle halted=0, instret=0, imem_addr=RESET_PC, x1 reads 0 after restart.
